hex_digit_counter: RTL and testbench

- Sequential source stage that drives the 4-bit input of the 7-segment decoder.
- Produces a hex digit that steps at a prescaled rate (default 1 Hz from the 50 MHz board clock).
- Supports up/down counting, run/pause, parallel load from switches, and a wrap-carry pulse for cascading further digits.
- The `digit` output connects directly to the decoder's 4-bit value input.

---
 rtl/hex_disp_pkg.sv | 6 +
 rtl/hex_digit_counter_tick_prescaler.sv | 17 +
 rtl/hex_digit_counter.sv | 60 ++++++
 tb/tb_hex_digit_counter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg: shared digit type and board constants for the hex display path
package hex_disp_pkg;
  typedef logic [3:0] digit_t;
  localparam int CLK_HZ = 50000000;
  localparam digit_t HEX_MAX = 4'hF;
endpackage

// File: rtl/hex_digit_counter_tick_prescaler.sv
// tick_prescaler: free-running divider with enable hold and terminal-count strobe
module tick_prescaler
  import hex_disp_pkg::*;
#(
  parameter int TICK_DIV = CLK_HZ,
  parameter int CNT_W = 26
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [CNT_W-1:0] cnt;
  assign tc = en && cnt == CNT_W'(TICK_DIV - 1);
  always_ff @(posedge clk)
    cnt <= (clr || tc) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/hex_digit_counter.sv
// hex_digit_counter: prescaled up/down hex digit with load and wrap carry
// HEX_DIGIT_COUNTER_STEP_EN adds a synchronized single-step pushbutton input.
module hex_digit_counter
  import hex_disp_pkg::*;
#(
  parameter int TICK_DIV = CLK_HZ,
  parameter int CNT_W = 26,
  parameter int MAX_DIGIT = int'(HEX_MAX)
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       step,
  output logic [3:0] digit,
  output logic       tick,
  output logic       carry
);
  localparam digit_t DMAX = digit_t'(MAX_DIGIT);
  logic tc, ev, wrap;
  digit_t nxt;
  tick_prescaler #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_pre (
    .clk(CLOCK_50),
    .clr(reset | load),
    .en (enable),
    .tc (tc)
  );
`ifdef HEX_DIGIT_COUNTER_STEP_EN
  logic [2:0] sync;
  always_ff @(posedge CLOCK_50)
    sync <= reset ? '0 : {sync[1:0], step};
  // a step edge and a terminal count in the same cycle merge into one event
  assign ev = tc | (sync[1] & ~sync[2]);
`else
  logic unused_step;
  assign unused_step = step;
  assign ev = tc;
`endif
  always_comb begin
    wrap = up ? digit == DMAX : digit == 4'd0;
    nxt = wrap ? (up ? 4'd0 : DMAX) : (up ? digit + 4'd1 : digit - 4'd1);
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      digit <= '0;
      tick <= 1'b0;
      carry <= 1'b0;
    end else if (load) begin
      digit <= (load_value > DMAX) ? DMAX : load_value;
      tick <= 1'b0;
      carry <= 1'b0;
    end else begin
      digit <= ev ? nxt : digit;
      tick <= ev;
      carry <= ev & wrap;
    end
  end
endmodule

// File: tb/tb_hex_digit_counter.sv
// tb_hex_digit_counter: scoreboard bench for hex_digit_counter (hex and decimal instances)
module tb_hex_digit_counter;
  typedef struct packed {logic [3:0] d; logic c;} exp_t;
  logic clk = 0;
  logic rst, en, up, ld, stp, b_en, b_up, b_ld;
  logic [3:0] lv, b_lv, a_digit, b_digit;
  logic a_tick, a_carry, b_tick, b_carry;
  exp_t qa[$], qb[$];
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  hex_digit_counter #(.TICK_DIV(4), .CNT_W(3), .MAX_DIGIT(15)) dut_a (
    .CLOCK_50(clk), .reset(rst), .enable(en), .up(up), .load(ld), .load_value(lv),
    .step(stp), .digit(a_digit), .tick(a_tick), .carry(a_carry)
  );
  hex_digit_counter #(.TICK_DIV(4), .CNT_W(3), .MAX_DIGIT(9)) dut_b (
    .CLOCK_50(clk), .reset(rst), .enable(b_en), .up(b_up), .load(b_ld), .load_value(b_lv),
    .step(1'b0), .digit(b_digit), .tick(b_tick), .carry(b_carry)
  );

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_tick) begin
      if (qa.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_unexpected_tick: digit %0h carry %0b with no expected step at %0t", a_digit, a_carry, $time);
      end else begin
        e = qa.pop_front();
        check("a_step_digit", 8'(a_digit), 8'(e.d));
        check("a_step_carry", 8'(a_carry), 8'(e.c));
      end
    end else if (a_carry) check("a_carry_without_tick", 8'(a_carry), 8'd0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_tick) begin
      if (qb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_unexpected_tick: digit %0h carry %0b with no expected step at %0t", b_digit, b_carry, $time);
      end else begin
        e = qb.pop_front();
        check("b_step_digit", 8'(b_digit), 8'(e.d));
        check("b_step_carry", 8'(b_carry), 8'(e.c));
      end
    end else if (b_carry) check("b_carry_without_tick", 8'(b_carry), 8'd0);
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; en = 0; up = 1; ld = 0; lv = 0; stp = 0;
    b_en = 0; b_up = 1; b_ld = 0; b_lv = 0;
    cyc(2);
    check("reset_digit", 8'(a_digit), 8'd0);
    check("reset_tick", 8'(a_tick), 8'd0);
    check("reset_carry", 8'(a_carry), 8'd0);
    check("reset_b_digit", 8'(b_digit), 8'd0);
    rst = 0; en = 1; up = 1;
    for (int k = 1; k <= 17; k++) qa.push_back({4'(k % 16), k == 16});
    cyc(70);
    check("run70_digit", 8'(a_digit), 8'd1);
    en = 0;
    cyc(10);
    check("pause_digit", 8'(a_digit), 8'd1);
    en = 1;
    qa.push_back({4'd2, 1'b0});
    cyc(1);
    check("resume_1cyc_tick", 8'(a_tick), 8'd0);
    cyc(1);
    check("resume_2cyc_tick", 8'(a_tick), 8'd1);
    ld = 1; lv = 4'h0;
    cyc(1);
    check("load0_digit", 8'(a_digit), 8'd0);
    ld = 0; up = 0;
    qa.push_back({4'd15, 1'b1});
    qa.push_back({4'd14, 1'b0});
    cyc(8);
    check("down_digit", 8'(a_digit), 8'd14);
    cyc(3);
    ld = 1; lv = 4'hA; up = 1;
    cyc(1);
    check("load_tc_digit", 8'(a_digit), 8'hA);
    check("load_tc_tick", 8'(a_tick), 8'd0);
    check("load_tc_carry", 8'(a_carry), 8'd0);
    ld = 0;
    qa.push_back({4'd11, 1'b0});
    cyc(3);
    check("after_load_3cyc_tick", 8'(a_tick), 8'd0);
    cyc(1);
    check("after_load_4cyc_tick", 8'(a_tick), 8'd1);
    ld = 1; lv = 4'h3;
    cyc(1);
    check("held_load_3", 8'(a_digit), 8'h3);
    lv = 4'h7;
    cyc(5);
    check("held_load_7", 8'(a_digit), 8'h7);
    check("held_load_tick", 8'(a_tick), 8'd0);
    ld = 0;
    qa.push_back({4'd8, 1'b0});
    cyc(3);
    check("held_release_3cyc_tick", 8'(a_tick), 8'd0);
    cyc(1);
    check("held_release_4cyc_tick", 8'(a_tick), 8'd1);
    cyc(3);
    rst = 1;
    cyc(1);
    check("reset_mid_digit", 8'(a_digit), 8'd0);
    check("reset_mid_tick", 8'(a_tick), 8'd0);
    check("reset_mid_carry", 8'(a_carry), 8'd0);
    rst = 0; en = 0;
`ifdef HEX_DIGIT_COUNTER_STEP_EN
    stp = 1;
    qa.push_back({4'd1, 1'b0});
    cyc(2);
    check("step_2cyc_tick", 8'(a_tick), 8'd0);
    cyc(1);
    check("step_3cyc_tick", 8'(a_tick), 8'd1);
    cyc(2);
    stp = 0;
    cyc(4);
    check("step_once_digit", 8'(a_digit), 8'd1);
`else
    stp = 1;
    cyc(5);
    stp = 0;
    cyc(4);
    check("step_ignored_digit", 8'(a_digit), 8'd0);
`endif
    stp = 1;
    cyc(2);
    ld = 1; lv = 4'h5;
    cyc(1);
    check("step_load_digit", 8'(a_digit), 8'h5);
    check("step_load_tick", 8'(a_tick), 8'd0);
    ld = 0;
    cyc(3);
    stp = 0;
    cyc(4);
    check("step_load_consumed", 8'(a_digit), 8'h5);
    b_ld = 1; b_lv = 4'hC;
    cyc(1);
    check("b_load_clamp_c", 8'(b_digit), 8'd9);
    b_lv = 4'hF;
    cyc(1);
    check("b_load_clamp_f", 8'(b_digit), 8'd9);
    b_lv = 4'h4;
    cyc(1);
    check("b_load_4", 8'(b_digit), 8'd4);
    b_lv = 4'h9;
    cyc(1);
    check("b_load_9", 8'(b_digit), 8'd9);
    b_ld = 0; b_en = 1; b_up = 1;
    qb.push_back({4'd0, 1'b1});
    cyc(4);
    check("b_wrap_up_digit", 8'(b_digit), 8'd0);
    b_up = 0;
    qb.push_back({4'd9, 1'b1});
    cyc(4);
    check("b_wrap_down_digit", 8'(b_digit), 8'd9);
    b_en = 0;
    cyc(2);
    check("a_queue_drained", 8'(qa.size()), 8'd0);
    check("b_queue_drained", 8'(qb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
